// File: rtl/cordic_mode_sel_decoder.sv
// -----------------------------------------------------------------------------
// cordic_mode_sel_decoder
//
// Purpose:
//   Takes the registered 3-bit one-hot mode select from the FPU control path,
//   validates it, and turns it back into the 2-bit mode code that drives the
//   CORDIC datapath muxes. The code is then issued over a programmed number of
//   iterations. Each iteration carries an index and a last flag. A done pulse
//   follows the final iteration. This block sits between the FPU interface
//   control FSM and the CORDIC iteration datapath.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active-high
//   sel_valid_i   one-hot select offered
//   sel_ready_o   block can accept a select (high only in IDLE)
//   sel_onehot_i  mode select: 001, 010, 100 or 000 (others are illegal)
//   iter_cnt_i    number of iterations to issue, sampled on accept
//   hold_i        stall: freezes the iteration sequence
//   abort_i       cancel the sequence in progress (RUN or DONE)
//   code_o        decoded mode code
//   code_valid_o  code_o / iter_idx_o valid for the current iteration
//   iter_idx_o    current iteration index, 0-based
//   last_o        current iteration is the final one
//   done_o        one-cycle pulse after the final iteration
//   err_o         one-cycle pulse after an illegal select is accepted
// -----------------------------------------------------------------------------
module cordic_mode_sel_decoder #(
    parameter int W_ITER = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel_valid_i,
    output logic              sel_ready_o,
    input  logic [2:0]        sel_onehot_i,
    input  logic [W_ITER-1:0] iter_cnt_i,
    input  logic              hold_i,
    input  logic              abort_i,
    output logic [1:0]        code_o,
    output logic              code_valid_o,
    output logic [W_ITER-1:0] iter_idx_o,
    output logic              last_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [W_ITER-1:0] cnt_q, cnt_d;
    logic [1:0]        code_d;
    logic [W_ITER-1:0] idx_d;
    logic              valid_d, last_d, done_d, err_d;

    logic              sel_legal;
    logic [1:0]        sel_code;

    // One-hot back to binary. "No bit set" is a legal mode and maps to 11.
    always_comb begin
        sel_legal = 1'b1;
        sel_code  = 2'b00;
        case (sel_onehot_i)
            3'b001:  sel_code = 2'b00;
            3'b010:  sel_code = 2'b01;
            3'b100:  sel_code = 2'b10;
            3'b000:  sel_code = 2'b11;
            default: sel_legal = 1'b0;
        endcase
    end

    // Ready is a pure decode of the state register, so it has no input-to-output path.
    assign sel_ready_o = (state_q == IDLE);

    // Next-state and next-output logic. Every output is registered from these *_d values.
    always_comb begin
        // NOTE: every signal gets a default before the case statement. A path that does
        // not assign a signal would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_o;
        idx_d   = iter_idx_o;
        valid_d = code_valid_o;
        last_d  = last_o;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                idx_d   = '0;
                if (sel_valid_i) begin
                    if (!sel_legal) begin
                        err_d = 1'b1;
                    end else if (iter_cnt_i != '0) begin
                        state_d = RUN;
                        cnt_d   = iter_cnt_i;
                        code_d  = sel_code;
                        valid_d = 1'b1;
                        last_d  = (iter_cnt_i == W_ITER'(1));
                    end else begin
                        // A zero-length request produces only the done pulse.
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            RUN: begin
                // Abort has priority over hold and over the last-iteration exit.
                if (abort_i) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    idx_d   = '0;
                end else if (!hold_i) begin
                    if (last_o) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        idx_d   = '0;
                    end else begin
                        // The last flag is set together with the index it belongs to,
                        // so it is aligned with that index. The index stops at
                        // cnt_q-1 and does not wrap.
                        idx_d  = iter_idx_o + W_ITER'(1);
                        last_d = ((iter_idx_o + W_ITER'(1)) == (cnt_q - W_ITER'(1)));
                    end
                end
            end

            DONE: begin
                // The done pulse lasts one cycle. Abort also leads back to IDLE.
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                idx_d   = '0;
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                idx_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments. All registers then update
    // together and see the values they had before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            code_o       <= 2'b00;
            iter_idx_o   <= '0;
            code_valid_o <= 1'b0;
            last_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            code_o       <= code_d;
            iter_idx_o   <= idx_d;
            code_valid_o <= valid_d;
            last_o       <= last_d;
            done_o       <= done_d;
            err_o        <= err_d;
        end
    end

endmodule

// File: tb/tb_cordic_mode_sel_decoder.sv
// -----------------------------------------------------------------------------
// tb_cordic_mode_sel_decoder
//
// Self-checking bench. A reference model turns each accepted request into the
// full list of output cycles it should produce: N iteration cycles and then a
// done cycle. That list is kept in a queue. Each clock, the model either repeats
// the front entry (hold), drops the whole queue (abort), or pops the front entry.
// When the queue is empty, the block is idle and ready. The DUT is compared with
// the model on every falling edge.
// -----------------------------------------------------------------------------
module tb_cordic_mode_sel_decoder;

    localparam int W_ITER = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              sel_valid;
    logic              sel_ready;
    logic [2:0]        sel_onehot;
    logic [W_ITER-1:0] iter_cnt;
    logic              hold;
    logic              abort;
    logic [1:0]        code;
    logic              code_valid;
    logic [W_ITER-1:0] iter_idx;
    logic              last;
    logic              done;
    logic              err;

    cordic_mode_sel_decoder #(.W_ITER(W_ITER)) dut (
        .clk          (clk),
        .rst          (rst),
        .sel_valid_i  (sel_valid),
        .sel_ready_o  (sel_ready),
        .sel_onehot_i (sel_onehot),
        .iter_cnt_i   (iter_cnt),
        .hold_i       (hold),
        .abort_i      (abort),
        .code_o       (code),
        .code_valid_o (code_valid),
        .iter_idx_o   (iter_idx),
        .last_o       (last),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    // One expected output cycle.
    typedef struct {
        bit valid;
        int idx;
        bit last;
        bit done;
    } exp_cycle_t;

    exp_cycle_t exp_q[$];
    int         exp_code;
    bit         exp_err;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Mode code taken directly from the one-hot pattern. Returns -1 if the pattern is illegal.
    function automatic int ref_code(input logic [2:0] s);
        int ones = 0;
        int pos  = 0;
        for (int i = 0; i < 3; i++) begin
            if (s[i]) begin
                ones++;
                pos = i;
            end
        end
        if (ones == 0) return 3;
        if (ones == 1) return pos;
        return -1;
    endfunction

    // Advance the model by one rising edge, using the inputs held across that edge.
    task automatic model_step();
        exp_cycle_t e;
        int         c;
        if (exp_q.size() == 0) begin
            exp_err = 1'b0;
            if (sel_valid) begin
                c = ref_code(sel_onehot);
                if (c < 0) begin
                    exp_err = 1'b1;
                end else begin
                    if (iter_cnt != 0) exp_code = c;
                    for (int i = 0; i < int'(iter_cnt); i++) begin
                        e.valid = 1'b1; e.idx = i; e.last = (i == int'(iter_cnt) - 1); e.done = 1'b0;
                        exp_q.push_back(e);
                    end
                    e.valid = 1'b0; e.idx = 0; e.last = 1'b0; e.done = 1'b1;
                    exp_q.push_back(e);
                end
            end
        end else begin
            exp_err = 1'b0;
            if (abort)                           exp_q.delete();
            else if (exp_q[0].valid && hold)     ; // stalled: repeat this cycle
            else                                 void'(exp_q.pop_front());
        end
    endtask

    task automatic compare_all(input string ctx);
        if (exp_q.size() == 0) begin
            check({ctx, ".ready"}, 32'(sel_ready),  32'd1);
            check({ctx, ".valid"}, 32'(code_valid), 32'd0);
            check({ctx, ".last"},  32'(last),       32'd0);
            check({ctx, ".done"},  32'(done),       32'd0);
            check({ctx, ".idx"},   32'(iter_idx),   32'd0);
        end else begin
            check({ctx, ".ready"}, 32'(sel_ready),  32'd0);
            check({ctx, ".valid"}, 32'(code_valid), 32'(exp_q[0].valid));
            check({ctx, ".last"},  32'(last),       32'(exp_q[0].last));
            check({ctx, ".done"},  32'(done),       32'(exp_q[0].done));
            if (exp_q[0].valid) check({ctx, ".idx"}, 32'(iter_idx), 32'(exp_q[0].idx));
        end
        check({ctx, ".err"},  32'(err),  32'(exp_err));
        check({ctx, ".code"}, 32'(code), 32'(exp_code));
    endtask

    // Drive the inputs for one cycle (called at a falling edge), then clock and compare.
    task automatic step(input string ctx, input logic v, input logic [2:0] s,
                        input logic [W_ITER-1:0] c, input logic h, input logic a);
        sel_valid  = v;
        sel_onehot = s;
        iter_cnt   = c;
        hold       = h;
        abort      = a;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all(ctx);
    endtask

    task automatic idle_steps(input string ctx, input int n);
        for (int i = 0; i < n; i++) step(ctx, 1'b0, 3'b000, '0, 1'b0, 1'b0);
    endtask

    int saw_done;

    initial begin
        sel_valid = 1'b0; sel_onehot = 3'b000; iter_cnt = '0; hold = 1'b0; abort = 1'b0;
        exp_code = 0; exp_err = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        compare_all("reset");
        rst = 1'b0;

        // Mode 010 with 4 iterations.
        step("m010_acc", 1'b1, 3'b010, 5'd4, 1'b0, 1'b0);
        idle_steps("m010_run", 6);

        // Back-to-back: 000 with count 1, then 100 with count 2 as soon as ready returns.
        step("m000_acc", 1'b1, 3'b000, 5'd1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("m100_offer", 1'b1, 3'b100, 5'd2, 1'b0, 1'b0);
        idle_steps("m100_run", 4);

        // Illegal 110: err pulses for one cycle and the code is unchanged. Then a legal 001.
        step("ill_acc", 1'b1, 3'b110, 5'd3, 1'b0, 1'b0);
        check("ill_err_pulse", 32'(err), 32'd1);
        step("ok001_acc", 1'b1, 3'b001, 5'd2, 1'b0, 1'b0);
        check("ill_err_clear", 32'(err), 32'd0);
        idle_steps("ok001_run", 4);

        // Count 3 with a 2-cycle hold at idx 1: expect indices 0,1,1,1,2.
        step("hold_acc", 1'b1, 3'b010, 5'd3, 1'b0, 1'b0);
        step("hold_i1",  1'b0, 3'b000, 5'd0, 1'b0, 1'b0);
        step("hold_h1",  1'b0, 3'b000, 5'd0, 1'b1, 1'b0);
        step("hold_h2",  1'b0, 3'b000, 5'd0, 1'b1, 1'b0);
        check("hold_idx_frozen", 32'(iter_idx), 32'd1);
        idle_steps("hold_tail", 4);

        // Abort at idx 2 of count 5. Then abort with hold also high.
        step("abt_acc", 1'b1, 3'b100, 5'd5, 1'b0, 1'b0);
        idle_steps("abt_run", 2);
        check("abt_at_idx2", 32'(iter_idx), 32'd2);
        step("abt_go", 1'b0, 3'b000, 5'd0, 1'b0, 1'b1);
        step("abh_acc", 1'b1, 3'b001, 5'd5, 1'b0, 1'b0);
        step("abh_go",  1'b0, 3'b000, 5'd0, 1'b1, 1'b1);
        idle_steps("abh_after", 2);

        // Count 0 gives only a done pulse.
        step("cnt0_acc", 1'b1, 3'b001, 5'd0, 1'b0, 1'b0);
        check("cnt0_done", 32'(done), 32'd1);
        idle_steps("cnt0_after", 2);

        // Count 31: indices 0..30 and no wrap.
        step("cnt31_acc", 1'b1, 3'b100, 5'd31, 1'b0, 1'b0);
        saw_done = 0;
        for (int i = 0; i < 34; i++) begin
            step("cnt31_run", 1'b0, 3'b000, 5'd0, 1'b0, 1'b0);
            if (done) saw_done++;
        end
        check("cnt31_one_done", 32'(saw_done), 32'd1);

        // Asynchronous reset in the middle of RUN clears outputs before any clock edge.
        step("arst_acc", 1'b1, 3'b010, 5'd6, 1'b0, 1'b0);
        idle_steps("arst_run", 2);
        rst = 1'b1;
        #1;
        exp_q.delete();
        exp_code = 0;
        exp_err  = 1'b0;
        compare_all("arst_imm");
        #1 rst = 1'b0;
        idle_steps("arst_after", 2);

        // Random stimulus.
        for (int n = 0; n < 3000; n++) begin
            logic              v, h, a;
            logic [2:0]        s;
            logic [W_ITER-1:0] c;
            v = ($urandom_range(0, 2) != 0);
            s = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'(1 << $urandom_range(0, 3));
            c = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
            h = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 19) == 0);
            step("rand", v, s, c, h, a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cordic_mode_sel_decoder.md
Name: cordic_mode_sel_decoder

Overview:
- Inverse of the CORDIC priority/one-hot mode encoder.
- Accepts a registered 3-bit one-hot mode select from the FPU control path and validates it.
- Converts it back to the 2-bit mode code the CORDIC datapath muxes consume.
- Sequences that code across a programmed number of CORDIC iterations with an iteration index, a last flag, and a done pulse. It sits between the FPU interface control FSM and the CORDIC iteration datapath.

Parameters:
- W_ITER, 5, width of the iteration count and index (max 2^W_ITER-1 iterations).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- sel_valid_i  input  1  one-hot select offered.
- sel_ready_o  output  1  block can accept a select.
- sel_onehot_i  input  3  mode select: 001, 010, 100 or 000.
- iter_cnt_i  input  W_ITER  number of iterations to issue; sampled on accept.
- hold_i  input  1  stall; freezes the iteration sequence.
- abort_i  input  1  cancel the sequence in progress.
- code_o  output  2  decoded mode code.
- code_valid_o  output  1  code_o/iter_idx_o valid for the current iteration.
- iter_idx_o  output  W_ITER  current iteration index, 0-based.
- last_o  output  1  current iteration is the final one.
- done_o  output  1  one-cycle pulse after the final iteration.
- err_o  output  1  one-cycle pulse when an illegal select is offered.

Behaviour:
- All outputs are registered. sel_ready_o is a decode of state.
- Reset (async, rst=1): state=IDLE, sel_ready_o=1, code_o=00, iter_idx_o=0, and code_valid_o, last_o, done_o, err_o all 0.
- Decode on accept (sel_valid_i & sel_ready_o at a rising edge):
  - 001 -> 00
  - 010 -> 01
  - 100 -> 10
  - 000 -> 11
  - Any other pattern (011, 101, 110, 111) is illegal.
- States: IDLE, RUN, DONE.
- IDLE:
  - sel_ready_o=1.
  - Legal accept with iter_cnt_i>0: latch the code and count, iter_idx_o=0, go to RUN.
  - Legal accept with iter_cnt_i=0: go to DONE. No code_valid_o cycles.
  - Illegal accept: err_o=1 for the next cycle only, stay in IDLE, code_o unchanged.
- RUN:
  - sel_ready_o=0, code_valid_o=1, code_o holds the latched code.
  - last_o=1 when iter_idx_o==count-1.
  - Each cycle with hold_i=0: if last, go to DONE; else iter_idx_o+1.
  - hold_i=1: all outputs frozen, code_valid_o stays 1.
- DONE: done_o=1 for exactly one cycle. code_valid_o=0, last_o=0, sel_ready_o=0. Next cycle go to IDLE.
- abort_i in RUN or DONE: next cycle go to IDLE. code_valid_o=0, last_o=0, iter_idx_o=0, no done_o pulse. abort_i has priority over hold_i and over the last-iteration transition. abort_i in IDLE is ignored.
- Latency:
  - Accept at edge k -> code_valid_o high from cycle k+1 for N cycles (no hold).
  - done_o in cycle k+1+N.
  - sel_ready_o high again in cycle k+2+N.
- Inputs offered while sel_ready_o=0 are ignored. sel_onehot_i and iter_cnt_i are not sampled outside an accept.
- Count width: iter_cnt_i of 2^W_ITER-1 is legal; the index never wraps.
- Reset mid-RUN: immediate return to the reset values with no done_o pulse.

Test Plan:
- Reset, then offer 010 with iter_cnt_i=4 -> code_o=01, code_valid_o high 4 cycles, iter_idx_o 0,1,2,3, last_o with idx 3, done_o one cycle later, ready one cycle after that.
- Offer 000 with count=1, then 100 with count=2 back-to-back -> code 11 for 1 cycle; done; code 10 for 2 cycles; done. No overlap.
- Offer 110 -> err_o pulses exactly 1 cycle, sel_ready_o stays 1, code_valid_o stays 0. A following legal 001 -> code 00 sequence.
- Count=3, hold_i high for 2 cycles at idx 1 -> idx sequence 0,1,1,1,2, last_o only with idx 2, total 5 valid cycles.
- Abort at idx 2 of count=5; separately, abort and hold together -> both go IDLE next cycle, no done_o, ready=1.
- iter_cnt_i=0 and iter_cnt_i=31 (W_ITER=5) -> 0: done_o only, no valid cycles. 31: indices 0..30 with no wrap. Async rst asserted mid-RUN clears all outputs without waiting for a clock edge.
